pc_fetch: RTL

Program counter and instruction fetch stage directly upstream of the control unit. Consumes the controller's PcSel and the ALU jump target, and holds the PC. Fetches instructions from program memory over a req/ack handshake, registers them in an instruction register (IR), and presents the decoded OpCode, register and immediate fields to control and datapath.

---
 rtl/pc_fetch.sv | 90 +++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage: holds the PC, fetches over a req/ack
// handshake into the IR and slices the IR into opcode, register and immediate fields.
module pc_fetch #(
  parameter int unsigned          PC_WIDTH     = 8,
  parameter int unsigned          INSTR_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic [1:0]             PcSel,
  input  logic [PC_WIDTH-1:0]    JmpAddr,
  output logic                   MemReq,
  output logic [PC_WIDTH-1:0]    MemAddr,
  input  logic                   MemAck,
  input  logic [INSTR_WIDTH-1:0] MemRData,
  output logic [3:0]             OpCode,
  output logic [3:0]             RegAddr,
  output logic [7:0]             Imm,
  output logic                   InstrValid,
  output logic                   Stall,
  output logic [PC_WIDTH-1:0]    Pc
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StReq   = 2'd2;

  localparam logic [1:0] PcWait = 2'b00;
  localparam logic [1:0] PcInc  = 2'b01;
  localparam logic [1:0] PcJmp  = 2'b10;

  logic [1:0]             state, stateNext;
  logic [PC_WIDTH-1:0]    pc, pcNext;
  logic [INSTR_WIDTH-1:0] ir, irNext;
  logic                   instrValid, instrValidNext;

  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    irNext         = ir;
    instrValidNext = 1'b0;
    unique case (state)
      StStart: stateNext = StReq;
      StReq: begin
        if (MemAck) begin
          irNext         = MemRData;
          instrValidNext = 1'b1;
          stateNext      = StIdle;
        end
      end
      StIdle: begin
        // Reserved PcSel encoding behaves like PcWait.
        if (PcSel == PcInc) begin
          pcNext    = pc + PC_WIDTH'(1);
          stateNext = StReq;
        end else if (PcSel == PcJmp) begin
          pcNext    = JmpAddr;
          stateNext = StReq;
        end else if (PcSel == PcWait) begin
          stateNext = StIdle;
        end
      end
      default: stateNext = StStart;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= StStart;
      pc         <= RESET_VECTOR;
      ir         <= '0;
      instrValid <= 1'b0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      ir         <= irNext;
      instrValid <= instrValidNext;
    end
  end

  assign MemReq     = (state == StReq);
  assign MemAddr    = pc;
  assign Pc         = pc;
  assign Stall      = (state != StIdle);
  assign InstrValid = instrValid;
  assign OpCode     = ir[15:12];
  assign RegAddr    = ir[11:8];
  assign Imm        = ir[7:0];

endmodule
